// File: rtl/spu_rf_pkg.sv
// Shared defaults, FSM state type and immediate expansion for the dual-issue SPU register file.
package spu_rf_pkg;

  localparam int unsigned DEF_RFWIDTH = 128;
  localparam int unsigned DEF_DEPTH   = 128;
  localparam int unsigned DEF_REGBITS = 7;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} rf_state_e;

  function automatic logic [31:0] imm_word(input logic [15:0] imm16, input logic sext);
    return {{16{sext & imm16[15]}}, imm16};
  endfunction

  function automatic logic [DEF_RFWIDTH-1:0] imm_expand(input logic [15:0] imm16,
                                                        input logic        sext);
    return {(DEF_RFWIDTH/32){imm_word(imm16, sext)}};
  endfunction

endpackage

// File: rtl/spu_rf_clear.sv
// Post-reset zeroing sweep: clears two entries per cycle, then hands over to RUN.
module spu_rf_clear
  import spu_rf_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned REGBITS = DEF_REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  output logic               clear_en,
  output logic [REGBITS-1:0] clear_addr_e,
  output logic [REGBITS-1:0] clear_addr_o,
  output logic               init_busy
);

  localparam int unsigned LastK = DEPTH / 2 - 1;

  rf_state_e          r_state, w_state_nxt;
  logic [REGBITS-2:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    clear_en    = 1'b0;
    init_busy   = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        clear_en  = 1'b1;
        init_busy = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LastK[REGBITS-2:0]) w_state_nxt = ST_RUN;
      end
      ST_RUN: w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign clear_addr_e = {r_cnt, 1'b0};
  assign clear_addr_o = {r_cnt, 1'b1};

endmodule

// File: rtl/spu_regfile_dual.sv
// Dual-issue SPU register file: even/odd pipes, 3 registered reads and 1 write each,
// immediate loads, write-first bypass and write-conflict reporting.
module spu_regfile_dual
  import spu_rf_pkg::*;
#(
  parameter int unsigned RFWIDTH = DEF_RFWIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned REGBITS = DEF_REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  output logic               init_busy,
  input  logic               rd_en_e,
  input  logic [REGBITS-1:0] ra_e,
  input  logic [REGBITS-1:0] rb_e,
  input  logic [REGBITS-1:0] rc_e,
  output logic [RFWIDTH-1:0] rda_e,
  output logic [RFWIDTH-1:0] rdb_e,
  output logic [RFWIDTH-1:0] rdc_e,
  input  logic               rd_en_o,
  input  logic [REGBITS-1:0] ra_o,
  input  logic [REGBITS-1:0] rb_o,
  input  logic [REGBITS-1:0] rc_o,
  output logic [RFWIDTH-1:0] rda_o,
  output logic [RFWIDTH-1:0] rdb_o,
  output logic [RFWIDTH-1:0] rdc_o,
  input  logic               we_e,
  input  logic [REGBITS-1:0] wa_e,
  input  logic [RFWIDTH-1:0] wd_e,
  input  logic               imm_en_e,
  input  logic [15:0]        imm16_e,
  input  logic               imm_sext_e,
  input  logic               we_o,
  input  logic [REGBITS-1:0] wa_o,
  input  logic [RFWIDTH-1:0] wd_o,
  input  logic               imm_en_o,
  input  logic [15:0]        imm16_o,
  input  logic               imm_sext_o,
  output logic               wr_conflict
);

  logic               w_clear_en;
  logic [REGBITS-1:0] w_clear_addr_e, w_clear_addr_o;

  spu_rf_clear #(
    .DEPTH  (DEPTH),
    .REGBITS(REGBITS)
  ) u_clear (
    .clk         (clk),
    .reset       (reset),
    .clear_en    (w_clear_en),
    .clear_addr_e(w_clear_addr_e),
    .clear_addr_o(w_clear_addr_o),
    .init_busy   (init_busy)
  );

  logic [RFWIDTH-1:0] r_mem [DEPTH];
  logic [RFWIDTH-1:0] r_rd  [6];
  logic               r_conflict;

  logic               w_run, w_same, w_wen_e, w_wen_o, w_commit_e;
  logic [RFWIDTH-1:0] w_wdat_e, w_wdat_o;
  logic [REGBITS-1:0] w_raddr [6];
  logic [RFWIDTH-1:0] w_rval  [6];

  assign w_run      = ~reset & ~init_busy;
  assign w_same     = (wa_e == wa_o);
  assign w_wen_e    = w_run & (we_e | imm_en_e);
  assign w_wen_o    = w_run & (we_o | imm_en_o);
  // Odd pipe is later in program order, so it owns a shared target address.
  assign w_commit_e = w_wen_e & ~(w_wen_o & w_same);
  assign w_wdat_e   = we_e ? wd_e : {(RFWIDTH/32){imm_word(imm16_e, imm_sext_e)}};
  assign w_wdat_o   = we_o ? wd_o : {(RFWIDTH/32){imm_word(imm16_o, imm_sext_o)}};

  always_ff @(posedge clk) begin
    if (w_clear_en && !reset) begin
      r_mem[w_clear_addr_e] <= '0;
      r_mem[w_clear_addr_o] <= '0;
    end else begin
      if (w_commit_e) r_mem[wa_e] <= w_wdat_e;
      if (w_wen_o)    r_mem[wa_o] <= w_wdat_o;
    end
  end

  assign w_raddr[0] = ra_e;
  assign w_raddr[1] = rb_e;
  assign w_raddr[2] = rc_e;
  assign w_raddr[3] = ra_o;
  assign w_raddr[4] = rb_o;
  assign w_raddr[5] = rc_o;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_rval[i] = r_mem[w_raddr[i]];
      if (w_commit_e && (w_raddr[i] == wa_e)) w_rval[i] = w_wdat_e;
      if (w_wen_o && (w_raddr[i] == wa_o))    w_rval[i] = w_wdat_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || init_busy) begin
      for (int i = 0; i < 6; i++) r_rd[i] <= '0;
      r_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if ((i < 3) ? rd_en_e : rd_en_o) r_rd[i] <= w_rval[i];
      end
      r_conflict <= (we_e & imm_en_e) | (we_o & imm_en_o) | (w_wen_e & w_wen_o & w_same);
    end
  end

  assign rda_e       = r_rd[0];
  assign rdb_e       = r_rd[1];
  assign rdc_e       = r_rd[2];
  assign rda_o       = r_rd[3];
  assign rdb_o       = r_rd[4];
  assign rdc_o       = r_rd[5];
  assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_spu_regfile_dual.sv
// Directed, table-driven bench for spu_regfile_dual (default 128x128 configuration).
module tb_spu_regfile_dual;

  typedef struct {
    logic         rd_en;
    logic [6:0]   ra, rb, rc;
    logic         we;
    logic [6:0]   wa;
    logic [127:0] wd;
    logic         imm_en;
    logic [15:0]  imm16;
    logic         sext;
  } pipe_in_t;

  typedef struct {
    pipe_in_t     e, o;
    logic [127:0] ea, eb, ec, oa, ob, oc;
    logic         conf;
  } vec_t;

  localparam logic [127:0] Z  = '0;
  localparam logic [127:0] A  = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] B  = {4{32'hBBBB_BBBB}};
  localparam logic [127:0] C  = {4{32'hCCCC_CCCC}};
  localparam logic [127:0] D  = {4{32'hDDDD_DDDD}};
  localparam logic [127:0] F  = {4{32'hFFFF_0000}};
  localparam logic [127:0] P1 = {4{32'h1111_1111}};
  localparam logic [127:0] P2 = {4{32'h2222_2222}};
  localparam logic [127:0] P5 = {4{32'h5555_5555}};
  localparam logic [127:0] I1 = {4{32'hFFFF_8001}};
  localparam logic [127:0] I2 = {4{32'h0000_8001}};
  localparam logic [127:0] I3 = {4{32'h0000_7FFF}};
  localparam logic [127:0] I4 = {4{32'h0000_FFFF}};

  logic         clk = 1'b0;
  logic         reset;
  logic         init_busy, wr_conflict;
  logic         rd_en_e, rd_en_o, we_e, we_o, imm_en_e, imm_en_o, imm_sext_e, imm_sext_o;
  logic [6:0]   ra_e, rb_e, rc_e, ra_o, rb_o, rc_o, wa_e, wa_o;
  logic [127:0] rda_e, rdb_e, rdc_e, rda_o, rdb_o, rdc_o, wd_e, wd_o;
  logic [15:0]  imm16_e, imm16_o;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [10];

  always #5 clk = ~clk;

  spu_regfile_dual dut (
    .clk        (clk),
    .reset      (reset),
    .init_busy  (init_busy),
    .rd_en_e    (rd_en_e),
    .ra_e       (ra_e),
    .rb_e       (rb_e),
    .rc_e       (rc_e),
    .rda_e      (rda_e),
    .rdb_e      (rdb_e),
    .rdc_e      (rdc_e),
    .rd_en_o    (rd_en_o),
    .ra_o       (ra_o),
    .rb_o       (rb_o),
    .rc_o       (rc_o),
    .rda_o      (rda_o),
    .rdb_o      (rdb_o),
    .rdc_o      (rdc_o),
    .we_e       (we_e),
    .wa_e       (wa_e),
    .wd_e       (wd_e),
    .imm_en_e   (imm_en_e),
    .imm16_e    (imm16_e),
    .imm_sext_e (imm_sext_e),
    .we_o       (we_o),
    .wa_o       (wa_o),
    .wd_o       (wd_o),
    .imm_en_o   (imm_en_o),
    .imm16_o    (imm16_o),
    .imm_sext_o (imm_sext_o),
    .wr_conflict(wr_conflict)
  );

  function automatic pipe_in_t pin(input logic rd_en, input logic [6:0] ra, rb, rc,
                                   input logic we, input logic [6:0] wa,
                                   input logic [127:0] wd, input logic imm_en,
                                   input logic [15:0] imm16, input logic sext);
    pipe_in_t p;
    p.rd_en = rd_en; p.ra = ra; p.rb = rb; p.rc = rc;
    p.we = we; p.wa = wa; p.wd = wd;
    p.imm_en = imm_en; p.imm16 = imm16; p.sext = sext;
    return p;
  endfunction

  task automatic drive(input pipe_in_t e, input pipe_in_t o);
    rd_en_e = e.rd_en; ra_e = e.ra; rb_e = e.rb; rc_e = e.rc;
    we_e = e.we; wa_e = e.wa; wd_e = e.wd;
    imm_en_e = e.imm_en; imm16_e = e.imm16; imm_sext_e = e.sext;
    rd_en_o = o.rd_en; ra_o = o.ra; rb_o = o.rb; rc_o = o.rc;
    we_o = o.we; wa_o = o.wa; wd_o = o.wd;
    imm_en_o = o.imm_en; imm16_o = o.imm16; imm_sext_o = o.sext;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts rising edges after reset release until init_busy drops.
  task automatic wait_init(output int cycles, output logic saw_conf);
    cycles = 0;
    saw_conf = 1'b0;
    while (init_busy === 1'b1 && cycles < 200) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (wr_conflict !== 1'b0 || rda_e !== Z || rda_o !== Z) saw_conf = 1'b1;
    end
  endtask

  pipe_in_t idle;
  int       cyc;
  logic     bad;

  initial begin
    idle = pin(0, 0, 0, 0, 0, 0, Z, 0, 0, 0);
    drive(idle, idle);
    reset = 1'b1;

    vecs[0] = '{e: pin(0, 0, 0, 0, 1, 10, A, 0, 0, 0), o: pin(0, 0, 0, 0, 1, 11, B, 0, 0, 0),
                ea: Z, eb: Z, ec: Z, oa: Z, ob: Z, oc: Z, conf: 0};
    vecs[1] = '{e: pin(1, 10, 11, 5, 0, 0, Z, 0, 0, 0), o: idle,
                ea: A, eb: B, ec: Z, oa: Z, ob: Z, oc: Z, conf: 0};
    vecs[2] = '{e: pin(0, 0, 0, 0, 1, 20, P1, 0, 0, 0),
                o: pin(1, 20, 10, 127, 1, 20, P2, 0, 0, 0),
                ea: A, eb: B, ec: Z, oa: P2, ob: A, oc: Z, conf: 1};
    vecs[3] = '{e: pin(1, 20, 0, 11, 0, 0, Z, 0, 0, 0), o: idle,
                ea: P2, eb: Z, ec: B, oa: P2, ob: A, oc: Z, conf: 0};
    vecs[4] = '{e: idle, o: pin(1, 7, 20, 3, 0, 7, Z, 1, 16'h8001, 1),
                ea: P2, eb: Z, ec: B, oa: I1, ob: P2, oc: Z, conf: 0};
    vecs[5] = '{e: pin(1, 7, 8, 9, 0, 8, Z, 1, 16'h7FFF, 1),
                o: pin(0, 0, 0, 0, 0, 7, Z, 1, 16'h8001, 0),
                ea: I2, eb: I3, ec: Z, oa: I1, ob: P2, oc: Z, conf: 0};
    vecs[6] = '{e: pin(0, 0, 0, 0, 1, 9, P5, 1, 16'h1234, 0),
                o: pin(1, 9, 8, 7, 0, 0, Z, 0, 0, 0),
                ea: I2, eb: I3, ec: Z, oa: P5, ob: I3, oc: I2, conf: 1};
    vecs[7] = '{e: idle, o: pin(0, 0, 0, 0, 1, 9, C, 0, 0, 0),
                ea: I2, eb: I3, ec: Z, oa: P5, ob: I3, oc: I2, conf: 0};
    vecs[8] = '{e: pin(1, 9, 9, 10, 0, 0, Z, 0, 0, 0), o: idle,
                ea: C, eb: C, ec: A, oa: P5, ob: I3, oc: I2, conf: 0};
    vecs[9] = '{e: pin(1, 127, 0, 20, 0, 127, Z, 1, 16'hFFFF, 0),
                o: pin(0, 0, 0, 0, 1, 0, D, 0, 0, 0),
                ea: I4, eb: D, ec: P2, oa: P5, ob: I3, oc: I2, conf: 0};

    // Reset and sweep
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_init_busy", 128'(init_busy), 128'(1));
    chk("reset_rda_e", rda_e, Z);
    chk("reset_rdc_o", rdc_o, Z);
    chk("reset_conflict", 128'(wr_conflict), 128'(0));
    wait_init(cyc, bad);
    chk("init_busy_cycles", 128'(cyc), 128'(64));
    chk("init_outputs_quiet", 128'(bad), 128'(0));

    drive(pin(1, 5, 127, 0, 0, 0, Z, 0, 0, 0), idle);
    @(posedge clk);
    @(negedge clk);
    chk("read_r5_after_init", rda_e, Z);
    chk("read_r127_after_init", rdb_e, Z);

    foreach (vecs[i]) begin
      drive(vecs[i].e, vecs[i].o);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_rda_e", i), rda_e, vecs[i].ea);
      chk($sformatf("v%0d_rdb_e", i), rdb_e, vecs[i].eb);
      chk($sformatf("v%0d_rdc_e", i), rdc_e, vecs[i].ec);
      chk($sformatf("v%0d_rda_o", i), rda_o, vecs[i].oa);
      chk($sformatf("v%0d_rdb_o", i), rdb_o, vecs[i].ob);
      chk($sformatf("v%0d_rdc_o", i), rdc_o, vecs[i].oc);
      chk($sformatf("v%0d_conflict", i), 128'(wr_conflict), 128'(vecs[i].conf));
    end

    // Reset mid-RUN, then again mid-sweep, with conflicting writes held throughout INIT
    drive(idle, idle);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rerun_rda_e_zeroed", rda_e, Z);
    drive(pin(0, 0, 0, 0, 1, 3, F, 1, 16'h4321, 1), pin(0, 0, 0, 0, 1, 3, D, 0, 0, 0));
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("sweep30_busy", 128'(init_busy), 128'(1));
    chk("sweep30_conflict", 128'(wr_conflict), 128'(0));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_init(cyc, bad);
    chk("restart_busy_cycles", 128'(cyc), 128'(64));
    chk("restart_outputs_quiet", 128'(bad), 128'(0));

    drive(pin(1, 3, 9, 20, 0, 0, Z, 0, 0, 0), idle);
    @(posedge clk);
    @(negedge clk);
    chk("r3_after_restart", rda_e, Z);
    chk("r9_after_restart", rdb_e, Z);
    chk("r20_after_restart", rdc_e, Z);
    chk("restart_conflict", 128'(wr_conflict), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
